jtag_ir_dr_ctrl: RTL and testbench
==================================

Name: jtag_ir_dr_ctrl

Overview:
- Instruction-register and data-register controller sitting beside the TAP state controller in the ICS top.
- Consumes the TAP state strobes (CAPTUREIR/SHIFTIR/UPDATEIR/CAPTUREDR/SHIFTDR/UPDATEDR, TAP_RST, ENABLE).
- Holds the IR, decodes the current instruction, and sequences capture/shift/update of the selected DR (BYPASS, IDCODE, USER).
- Drives the TDO mux.

Parameters:
- IR_W, 4, instruction register width (>=2).
- IDCODE_VAL, 32'h1A2B_3C4D, IDCODE capture value; bit0 must be 1.
- USER_W, 8, user data register width.
- OP_IDCODE, 4'b0001, IDCODE opcode; also the reset instruction.
- OP_USER, 4'b0010, USER data register opcode.
- OP_BYPASS, all ones, BYPASS opcode.

Ports:
- TCK  in  1  test clock; all state updates on rising edge.
- TRST  in  1  asynchronous active-high reset.
- TAP_RST  in  1  synchronous reset level from TAP (Test-Logic-Reset).
- ENABLE  in  1  high in Shift-IR/Shift-DR; TDO output enable.
- CAPTUREIR, SHIFTIR, UPDATEIR  in  1 each  TAP IR state strobes.
- CAPTUREDR, SHIFTDR, UPDATEDR  in  1 each  TAP DR state strobes.
- TDI  in  1  serial in.
- TDO  out  1  serial out.
- USER_D  in  USER_W  parallel capture data for USER DR.
- USER_Q  out  USER_W  latched USER DR update value.
- USER_UPD  out  1  one-TCK pulse when USER_Q updated.
- IR_Q  out  IR_W  currently active instruction.

Behaviour:
- Reset (TRST async, or TAP_RST sync)
  - ir_sr = 0, IR_Q = OP_IDCODE, bypass_sr = 0, id_sr = 0, user_sr = 0.
  - USER_Q = 0, USER_UPD = 0.
  - TRST mid-shift aborts the scan immediately; no update occurs.
- Strobe priority (TAP guarantees exclusivity): TAP_RST > UPDATE* > CAPTURE* > SHIFT*.
- IR path
  - CAPTUREIR: ir_sr <= {0..., 2'b01}.
  - SHIFTIR: ir_sr <= {TDI, ir_sr[IR_W-1:1]}, LSB first.
  - UPDATEIR: IR_Q <= ir_sr.
- DR select, decoded from IR_Q
  - OP_IDCODE -> id_sr (32 bits).
  - OP_USER -> user_sr (USER_W bits).
  - OP_BYPASS or any undefined opcode -> bypass_sr (1 bit).
- DR capture (CAPTUREDR, selected register only)
  - bypass_sr <= 0.
  - id_sr <= IDCODE_VAL.
  - user_sr <= USER_D.
- DR shift (SHIFTDR, selected register only): right shift with TDI entering the MSB. Unselected registers hold.
- DR update
  - UPDATEDR with OP_USER: USER_Q <= user_sr, USER_UPD = 1 for exactly one TCK cycle, otherwise 0.
  - UPDATEDR with any other instruction: no effect.
- TDO (combinational)
  - SHIFTIR & ENABLE -> ir_sr[0].
  - SHIFTDR & ENABLE -> selected DR bit0.
  - Otherwise 0.
- Latency: the first captured bit appears on TDO in the first Shift cycle. N shift cycles move N bits. UPDATE takes effect the cycle after the Update strobe.
- IR changes affect DR selection only after UPDATEIR; a DR scan in progress is never redirected.

Test Plan:
- Apply TRST, release, CAPTUREDR then 32 SHIFTDR cycles -> IR_Q=0001; TDO stream LSB first = 32'h1A2B_3C4D.
- CAPTUREIR, 4 SHIFTIR with TDI=1,1,1,1, UPDATEIR -> TDO out 1,0,0,0; IR_Q=1111 (BYPASS).
- BYPASS active: CAPTUREDR, shift TDI=1,0,1,1,0,0,1,0 -> TDO = 0 then the TDI sequence delayed by exactly one cycle.
- Load IR=0010, USER_D=8'hA5, CAPTUREDR, shift in 8'h3C, UPDATEDR -> TDO shows A5 LSB first; USER_Q=8'h3C; USER_UPD high for exactly one TCK.
- Load IR=0101 (undefined) -> behaves as BYPASS (1-bit delay); USER_Q unchanged; USER_UPD stays 0.
- USER scan in progress, assert TRST after 3 shift cycles -> all registers reset; IR_Q=0001; USER_Q=0; no USER_UPD pulse. Subsequent IDCODE scan correct.

Source files
------------

// File: rtl/jtag_ir_dr_ctrl.sv
// jtag_ir_dr_ctrl: the JTAG instruction register and the data registers that
// sit beside the TAP state controller. The block holds the IR and decodes the
// active instruction. It captures, shifts and updates the selected data
// register (BYPASS, IDCODE or USER) and drives TDO.
module jtag_ir_dr_ctrl #(
  parameter int                 IR_W       = 4,
  parameter logic [31:0]        IDCODE_VAL = 32'h1A2B_3C4D,
  parameter int                 USER_W     = 8,
  parameter logic [IR_W-1:0]    OP_IDCODE  = 4'b0001,
  parameter logic [IR_W-1:0]    OP_USER    = 4'b0010,
  parameter logic [IR_W-1:0]    OP_BYPASS  = '1
) (
  input  logic              TCK,
  input  logic              TRST,
  input  logic              TAP_RST,
  input  logic              ENABLE,
  input  logic              CAPTUREIR,
  input  logic              SHIFTIR,
  input  logic              UPDATEIR,
  input  logic              CAPTUREDR,
  input  logic              SHIFTDR,
  input  logic              UPDATEDR,
  input  logic              TDI,
  output logic              TDO,
  input  logic [USER_W-1:0] USER_D,
  output logic [USER_W-1:0] USER_Q,
  output logic              USER_UPD,
  output logic [IR_W-1:0]   IR_Q
);

  // Data register currently routed between TDI and TDO.
  typedef enum logic [1:0] {
    SEL_BYPASS = 2'd0,
    SEL_IDCODE = 2'd1,
    SEL_USER   = 2'd2
  } dr_sel_e;

  // The value loaded by Capture-IR has '01' in its two LSBs, as 1149.1 requires.
  localparam logic [IR_W-1:0] IR_CAPTURE_VAL = {{(IR_W-2){1'b0}}, 2'b01};

  logic [IR_W-1:0]   ir_sr_q,     ir_sr_d;
  logic [IR_W-1:0]   ir_q,        ir_d;
  logic              bypass_q,    bypass_d;
  logic [31:0]       id_sr_q,     id_sr_d;
  logic [USER_W-1:0] user_sr_q,   user_sr_d;
  logic [USER_W-1:0] user_q_q,    user_q_d;
  logic              user_upd_q,  user_upd_d;
  dr_sel_e           sel;

  // Decode the active instruction. Selection follows ir_q only. A new opcode
  // that is still in ir_sr therefore cannot redirect a DR scan in progress.
  always_comb begin
    sel = SEL_BYPASS;
    if (ir_q == OP_IDCODE)      sel = SEL_IDCODE;
    else if (ir_q == OP_USER)   sel = SEL_USER;
    else if (ir_q == OP_BYPASS) sel = SEL_BYPASS;
  end

  // Next-state logic. Only one strobe is active at a time, and the if-chain
  // order sets the priority: TAP_RST, then update, then capture, then shift.
  always_comb begin
    // NOTE: every variable this block writes gets a hold value first, so no
    // branch can leave one unassigned and infer a latch.
    ir_sr_d    = ir_sr_q;
    ir_d       = ir_q;
    bypass_d   = bypass_q;
    id_sr_d    = id_sr_q;
    user_sr_d  = user_sr_q;
    user_q_d   = user_q_q;
    user_upd_d = 1'b0;

    if (TAP_RST) begin
      ir_sr_d   = '0;
      ir_d      = OP_IDCODE;
      bypass_d  = 1'b0;
      id_sr_d   = '0;
      user_sr_d = '0;
      user_q_d  = '0;
    end else if (UPDATEIR) begin
      ir_d = ir_sr_q;
    end else if (UPDATEDR) begin
      if (sel == SEL_USER) begin
        user_q_d   = user_sr_q;
        user_upd_d = 1'b1;
      end
    end else if (CAPTUREIR) begin
      ir_sr_d = IR_CAPTURE_VAL;
    end else if (CAPTUREDR) begin
      case (sel)
        SEL_IDCODE: id_sr_d   = IDCODE_VAL;
        SEL_USER:   user_sr_d = USER_D;
        default:    bypass_d  = 1'b0;
      endcase
    end else if (SHIFTIR) begin
      ir_sr_d = {TDI, ir_sr_q[IR_W-1:1]};
    end else if (SHIFTDR) begin
      case (sel)
        SEL_IDCODE: id_sr_d   = {TDI, id_sr_q[31:1]};
        SEL_USER:   user_sr_d = {TDI, user_sr_q[USER_W-1:1]};
        default:    bypass_d  = TDI;
      endcase
    end
  end

  // State registers. TRST resets them asynchronously and aborts any scan.
  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_sr_q    <= '0;
      ir_q       <= OP_IDCODE;
      bypass_q   <= 1'b0;
      id_sr_q    <= '0;
      user_sr_q  <= '0;
      user_q_q   <= '0;
      user_upd_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register sample the
      // pre-edge values, whatever order the statements are written in.
      ir_sr_q    <= ir_sr_d;
      ir_q       <= ir_d;
      bypass_q   <= bypass_d;
      id_sr_q    <= id_sr_d;
      user_sr_q  <= user_sr_d;
      user_q_q   <= user_q_d;
      user_upd_q <= user_upd_d;
    end
  end

  // TDO mux. It is driven only during an enabled shift, and is 0 otherwise.
  always_comb begin
    TDO = 1'b0;
    if (SHIFTIR && ENABLE) begin
      TDO = ir_sr_q[0];
    end else if (SHIFTDR && ENABLE) begin
      case (sel)
        SEL_IDCODE: TDO = id_sr_q[0];
        SEL_USER:   TDO = user_sr_q[0];
        default:    TDO = bypass_q;
      endcase
    end
  end

  assign IR_Q     = ir_q;
  assign USER_Q   = user_q_q;
  assign USER_UPD = user_upd_q;

endmodule

// File: tb/tb_jtag_ir_dr_ctrl.sv
// Directed testbench for jtag_ir_dr_ctrl. The expected values are worked out
// by hand from the register behaviour: IR load, IDCODE scan, BYPASS delay,
// USER capture/update, undefined opcodes and reset aborts.
module tb_jtag_ir_dr_ctrl;

  logic       TCK = 1'b0;
  logic       TRST, TAP_RST, ENABLE;
  logic       CAPTUREIR, SHIFTIR, UPDATEIR;
  logic       CAPTUREDR, SHIFTDR, UPDATEDR;
  logic       TDI, TDO;
  logic [7:0] USER_D, USER_Q;
  logic       USER_UPD;
  logic [3:0] IR_Q;

  int n_cmp = 0;
  int n_mis = 0;

  jtag_ir_dr_ctrl dut (
    .TCK(TCK), .TRST(TRST), .TAP_RST(TAP_RST), .ENABLE(ENABLE),
    .CAPTUREIR(CAPTUREIR), .SHIFTIR(SHIFTIR), .UPDATEIR(UPDATEIR),
    .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
    .TDI(TDI), .TDO(TDO), .USER_D(USER_D), .USER_Q(USER_Q),
    .USER_UPD(USER_UPD), .IR_Q(IR_Q)
  );

  always #5 TCK = ~TCK;

  // Inputs change 1 time unit after the rising edge, well away from it.
  task automatic step();
    @(posedge TCK);
    #1;
  endtask

  task automatic clear_strobes();
    TAP_RST = 0; ENABLE = 0; CAPTUREIR = 0; SHIFTIR = 0; UPDATEIR = 0;
    CAPTUREDR = 0; SHIFTDR = 0; UPDATEDR = 0; TDI = 0;
  endtask

  // Runs a full IR scan: capture, IR_W shifts LSB first, then update.
  task automatic load_ir(input logic [3:0] op, output logic [3:0] tdo_bits);
    clear_strobes();
    CAPTUREIR = 1; step(); CAPTUREIR = 0;
    SHIFTIR = 1; ENABLE = 1;
    for (int i = 0; i < 4; i++) begin
      TDI = op[i];
      #1 tdo_bits[i] = TDO;
      step();
    end
    SHIFTIR = 0; ENABLE = 0; TDI = 0;
    UPDATEIR = 1; step(); UPDATEIR = 0;
  endtask

  // Runs capture followed by n shift cycles and records TDO on each cycle.
  // The update strobe is left to the caller.
  task automatic scan_dr(input int n, input logic [31:0] tdi_bits,
                         output logic [31:0] tdo_bits);
    clear_strobes();
    tdo_bits = '0;
    CAPTUREDR = 1; step(); CAPTUREDR = 0;
    SHIFTDR = 1; ENABLE = 1;
    for (int i = 0; i < n; i++) begin
      TDI = tdi_bits[i];
      #1 tdo_bits[i] = TDO;
      step();
    end
    SHIFTDR = 0; ENABLE = 0; TDI = 0;
  endtask

  task automatic test_reset();
    clear_strobes();
    USER_D = 8'h00;
    TRST = 1;
    step(); step();
    n_cmp++; if (IR_Q !== 4'b0001) begin n_mis++; $display("FAIL reset_ir: got %b want 0001", IR_Q); end
    n_cmp++; if (USER_Q !== 8'h00) begin n_mis++; $display("FAIL reset_user_q: got %h want 00", USER_Q); end
    n_cmp++; if (USER_UPD !== 1'b0) begin n_mis++; $display("FAIL reset_user_upd: got %b want 0", USER_UPD); end
    n_cmp++; if (TDO !== 1'b0) begin n_mis++; $display("FAIL reset_tdo: got %b want 0", TDO); end
    TRST = 0;
    step();
  endtask

  task automatic test_idcode(input string tag);
    logic [31:0] tdo;
    scan_dr(32, 32'h0, tdo);
    n_cmp++; if (IR_Q !== 4'b0001) begin n_mis++; $display("FAIL %s_ir: got %b want 0001", tag, IR_Q); end
    n_cmp++; if (tdo !== 32'h1A2B_3C4D) begin n_mis++; $display("FAIL %s_tdo: got %h want 1a2b3c4d", tag, tdo); end
  endtask

  task automatic test_ir_bypass();
    logic [3:0] tdo;
    load_ir(4'b1111, tdo);
    n_cmp++; if (tdo !== 4'b0001) begin n_mis++; $display("FAIL ir_capture_tdo: got %b want 0001 (LSB first)", tdo); end
    n_cmp++; if (IR_Q !== 4'b1111) begin n_mis++; $display("FAIL ir_bypass: got %b want 1111", IR_Q); end
  endtask

  task automatic test_bypass();
    logic [31:0] tdo;
    // The TDI stream 1,0,1,1,0,0,1,0 is 8'h4D. Expected TDO is a 0 followed
    // by the same stream delayed one cycle: 0,1,0,1,1,0,0,1 = 8'h9A.
    scan_dr(8, 32'h4D, tdo);
    n_cmp++; if (tdo[7:0] !== 8'h9A) begin n_mis++; $display("FAIL bypass_tdo: got %h want 9a", tdo[7:0]); end
  endtask

  task automatic test_user();
    logic [3:0]  ir_tdo;
    logic [31:0] tdo;
    load_ir(4'b0010, ir_tdo);
    n_cmp++; if (IR_Q !== 4'b0010) begin n_mis++; $display("FAIL user_ir: got %b want 0010", IR_Q); end
    USER_D = 8'hA5;
    scan_dr(8, 32'h3C, tdo);
    n_cmp++; if (tdo[7:0] !== 8'hA5) begin n_mis++; $display("FAIL user_tdo: got %h want a5", tdo[7:0]); end
    n_cmp++; if (USER_Q !== 8'h00) begin n_mis++; $display("FAIL user_q_pre_update: got %h want 00", USER_Q); end
    UPDATEDR = 1;
    #1;
    n_cmp++; if (USER_UPD !== 1'b0) begin n_mis++; $display("FAIL user_upd_early: got %b want 0", USER_UPD); end
    step(); UPDATEDR = 0;
    n_cmp++; if (USER_Q !== 8'h3C) begin n_mis++; $display("FAIL user_q: got %h want 3c", USER_Q); end
    n_cmp++; if (USER_UPD !== 1'b1) begin n_mis++; $display("FAIL user_upd_pulse: got %b want 1", USER_UPD); end
    step();
    n_cmp++; if (USER_UPD !== 1'b0) begin n_mis++; $display("FAIL user_upd_width: got %b want 0", USER_UPD); end
    n_cmp++; if (USER_Q !== 8'h3C) begin n_mis++; $display("FAIL user_q_hold: got %h want 3c", USER_Q); end
  endtask

  task automatic test_undefined();
    logic [3:0]  ir_tdo;
    logic [31:0] tdo;
    load_ir(4'b0101, ir_tdo);
    n_cmp++; if (IR_Q !== 4'b0101) begin n_mis++; $display("FAIL undef_ir: got %b want 0101", IR_Q); end
    USER_D = 8'hFF;
    // TDI 8'hC3 shifted through the one-bit bypass register gives {C3[6:0],0} = 8'h86.
    scan_dr(8, 32'hC3, tdo);
    n_cmp++; if (tdo[7:0] !== 8'h86) begin n_mis++; $display("FAIL undef_tdo: got %h want 86", tdo[7:0]); end
    UPDATEDR = 1; step(); UPDATEDR = 0;
    n_cmp++; if (USER_UPD !== 1'b0) begin n_mis++; $display("FAIL undef_upd: got %b want 0", USER_UPD); end
    n_cmp++; if (USER_Q !== 8'h3C) begin n_mis++; $display("FAIL undef_user_q: got %h want 3c", USER_Q); end
  endtask

  task automatic test_tap_rst();
    logic [3:0] ir_tdo;
    load_ir(4'b0010, ir_tdo);
    TAP_RST = 1;
    #1;
    n_cmp++; if (IR_Q !== 4'b0010) begin n_mis++; $display("FAIL tap_rst_sync: got %b want 0010", IR_Q); end
    step(); TAP_RST = 0;
    n_cmp++; if (IR_Q !== 4'b0001) begin n_mis++; $display("FAIL tap_rst_ir: got %b want 0001", IR_Q); end
    n_cmp++; if (USER_Q !== 8'h00) begin n_mis++; $display("FAIL tap_rst_user_q: got %h want 00", USER_Q); end
  endtask

  task automatic test_trst_abort();
    logic [3:0] ir_tdo;
    load_ir(4'b0010, ir_tdo);
    USER_D = 8'h5A;
    CAPTUREDR = 1; step(); CAPTUREDR = 0;
    SHIFTDR = 1; ENABLE = 1; TDI = 1;
    step(); step(); step();
    TRST = 1;
    #1;
    n_cmp++; if (IR_Q !== 4'b0001) begin n_mis++; $display("FAIL abort_ir: got %b want 0001", IR_Q); end
    n_cmp++; if (USER_Q !== 8'h00) begin n_mis++; $display("FAIL abort_user_q: got %h want 00", USER_Q); end
    n_cmp++; if (TDO !== 1'b0) begin n_mis++; $display("FAIL abort_tdo: got %b want 0", TDO); end
    clear_strobes();
    step();
    TRST = 0;
    UPDATEDR = 1; step(); UPDATEDR = 0;
    n_cmp++; if (USER_UPD !== 1'b0) begin n_mis++; $display("FAIL abort_upd: got %b want 0", USER_UPD); end
    n_cmp++; if (USER_Q !== 8'h00) begin n_mis++; $display("FAIL abort_user_q_after: got %h want 00", USER_Q); end
  endtask

  initial begin
    TRST = 1;
    clear_strobes();
    USER_D = 8'h00;
    test_reset();
    test_idcode("idcode");
    test_ir_bypass();
    test_bypass();
    test_user();
    test_undefined();
    test_tap_rst();
    test_trst_abort();
    test_idcode("idcode_after_abort");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
